// File: rtl/sram_ctrl_sp.sv
// Single-port asynchronous SRAM controller: valid/ready requests in,
// cycle-counted CE/OE/WE/BE strobes out, one response per request.
module sram_ctrl_sp #(
    parameter int DW       = 32,
    parameter int AW       = 20,
    parameter int RD_CYC   = 2,
    parameter int WR_SETUP = 1,
    parameter int WR_PULSE = 2,
    parameter int WR_HOLD  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AW-1:0]     req_addr,
    input  logic [DW-1:0]     req_wdata,
    input  logic [DW/8-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]     rsp_rdata,
    inout  wire  [DW-1:0]     ram_data,
    output logic [AW-1:0]     ram_addr,
    output logic [DW/8-1:0]   ram_be_n,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    localparam int BW   = DW / 8;
    localparam int MAX1 = (RD_CYC > WR_SETUP) ? RD_CYC : WR_SETUP;
    localparam int MAX2 = (WR_PULSE > WR_HOLD) ? WR_PULSE : WR_HOLD;
    localparam int MAXC = (MAX1 > MAX2) ? MAX1 : MAX2;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] RD_LD = CW'(RD_CYC - 1);
    localparam logic [CW-1:0] WS_LD = CW'(WR_SETUP - 1);
    localparam logic [CW-1:0] WP_LD = CW'(WR_PULSE - 1);
    localparam logic [CW-1:0] WH_LD = CW'(WR_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WSETUP,
        WPULSE,
        WHOLD,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] wdata_q;
    logic          drive;

    assign req_ready = (state == IDLE) && !reset;

    // Data bus is driven only from the write states; enable is a flop.
    assign ram_data = drive ? wdata_q : {DW{1'bz}};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            wdata_q   <= '0;
            drive     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            ram_addr  <= '0;
            ram_be_n  <= {BW{1'b1}};
            ram_ce_n  <= 1'b1;
            ram_oe_n  <= 1'b1;
            ram_we_n  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        ram_addr <= req_addr;
                        ram_be_n <= ~req_be;
                        ram_ce_n <= 1'b0;
                        wdata_q  <= req_wdata;
                        if (req_we) begin
                            state     <= WSETUP;
                            cnt       <= WS_LD;
                            drive     <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state    <= RD;
                            cnt      <= RD_LD;
                            ram_oe_n <= 1'b0;
                        end
                    end
                end
                RD: begin
                    if (cnt == '0) begin
                        rsp_rdata <= ram_data;
                        rsp_valid <= 1'b1;
                        ram_ce_n  <= 1'b1;
                        ram_oe_n  <= 1'b1;
                        ram_be_n  <= {BW{1'b1}};
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WSETUP: begin
                    if (cnt == '0) begin
                        ram_we_n <= 1'b0;
                        cnt      <= WP_LD;
                        state    <= WPULSE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WPULSE: begin
                    if (cnt == '0) begin
                        ram_we_n <= 1'b1;
                        cnt      <= WH_LD;
                        state    <= WHOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WHOLD: begin
                    if (cnt == '0) begin
                        drive     <= 1'b0;
                        rsp_valid <= 1'b1;
                        ram_ce_n  <= 1'b1;
                        ram_be_n  <= {BW{1'b1}};
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
